// File: rtl/onegen_if.sv
// Handshake bundle for the one-run word generator: start/count/offset in,
// valid/ack result out.
interface onegen_if #(
  parameter int unsigned OUTPUTSIZE = 64
);
  localparam int unsigned CW = $clog2(OUTPUTSIZE + 1);
  localparam int unsigned PW = $clog2(OUTPUTSIZE);

  logic                  start_i;
  logic [CW-1:0]         count_i;
  logic [PW-1:0]         offset_i;
  logic                  ready_o;
  logic                  valid_o;
  logic                  ack_i;
  logic [OUTPUTSIZE-1:0] outport;

  // Requester / consumer side
  modport master (
    output start_i, count_i, offset_i, ack_i,
    input  ready_o, valid_o, outport
  );

  // Generator side
  modport slave (
    input  start_i, count_i, offset_i, ack_i,
    output ready_o, valid_o, outport
  );
endinterface

// File: rtl/onegen.sv
// One-run word generator: builds an OUTPUTSIZE-bit word holding a contiguous,
// circularly wrapping run of N ones starting at a programmable offset. One bit
// is set per cycle into a shadow word; the result is published only when done.
module onegen #(
  parameter int unsigned OUTPUTSIZE = 64
) (
  input  logic     clk,
  input  logic     rst,
  onegen_if.slave  bus
);
  localparam int unsigned CW = $clog2(OUTPUTSIZE + 1);
  localparam int unsigned PW = $clog2(OUTPUTSIZE);

  localparam logic [OUTPUTSIZE-1:0] OneLsb = {{(OUTPUTSIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

  state_e                r_state;
  logic [OUTPUTSIZE-1:0] r_word;
  logic [OUTPUTSIZE-1:0] r_outport;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_remaining;

  logic [CW-1:0]         w_count_sat;
  logic [PW-1:0]         w_ptr_start;
  logic [PW-1:0]         w_ptr_next;
  logic [OUTPUTSIZE-1:0] w_word_set;

  // Saturate the request, reduce the offset modulo the width, and form the
  // shadow word with the current pointer bit set.
  always_comb begin
    w_count_sat = bus.count_i;
    if (bus.count_i > CW'(OUTPUTSIZE)) begin
      w_count_sat = CW'(OUTPUTSIZE);
    end
    // Offset is below 2*OUTPUTSIZE, so one subtraction is a full modulo.
    w_ptr_start = bus.offset_i;
    if ({1'b0, bus.offset_i} >= (PW+1)'(OUTPUTSIZE)) begin
      w_ptr_start = bus.offset_i - PW'(OUTPUTSIZE);
    end
    w_ptr_next = (r_ptr == PW'(OUTPUTSIZE - 1)) ? '0 : r_ptr + PW'(1);
    w_word_set = r_word | (OneLsb << r_ptr);
  end

  // Handshake flags decode directly from the registered state.
  assign bus.ready_o = (r_state == StIdle);
  assign bus.valid_o = (r_state == StHold);
  assign bus.outport = r_outport;

  // Control FSM plus datapath: load on start, fill one bit per cycle, hold
  // until acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_outport   <= '0;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start_i) begin
            r_remaining <= w_count_sat;
            r_ptr       <= w_ptr_start;
            r_word      <= '0;
            if (w_count_sat == '0) begin
              r_outport <= '0;
              r_state   <= StHold;
            end else begin
              r_state <= StFill;
            end
          end
        end
        StFill: begin
          r_word      <= w_word_set;
          r_ptr       <= w_ptr_next;
          r_remaining <= r_remaining - CW'(1);
          if (r_remaining == CW'(1)) begin
            // Publish the word including the bit set on this final edge.
            r_outport <= w_word_set;
            r_state   <= StHold;
          end
        end
        StHold: begin
          if (bus.ack_i) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_onegen.sv
// Directed bench for onegen (OUTPUTSIZE=64): reset, zero count, wrap-around,
// saturation, ignored inputs, mid-fill reset, and a loop-back sweep.
module tb_onegen;
  localparam int unsigned W = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   lat;

  onegen_if #(.OUTPUTSIZE(W)) bus ();

  onegen #(.OUTPUTSIZE(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference word: bit (off+i) mod 64 set for i < min(n, 64).
  function automatic logic [63:0] model_word(input int n, input int off);
    logic [63:0] w;
    int          k;
    w = '0;
    k = (n > 64) ? 64 : n;
    for (int i = 0; i < k; i++) w[(off + i) % 64] = 1'b1;
    return w;
  endfunction

  // Issue one start and count edges after the start edge until valid_o.
  task automatic run(input int cnt, input int off, output int l);
    bus.count_i  = 7'(cnt);
    bus.offset_i = 6'(off);
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    l = 0;
    while (!bus.valid_o && l < 100) begin
      tick();
      l++;
    end
  endtask

  task automatic do_ack(input string tag);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.count_i  = '0;
    bus.offset_i = '0;
    bus.ack_i    = 1'b0;

    // Reset state
    #12;
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_out", bus.outport, 64'd0);
    rst = 1'b1;
    tick();

    // N=0: valid right after the start edge, all zeros
    run(0, 17, lat);
    check("n0_lat", 64'(lat), 64'd0);
    check("n0_out", bus.outport, 64'd0);
    check("n0_ready", 64'(bus.ready_o), 64'd0);
    do_ack("n0_ack");

    // Wrap-around from bit 62
    run(3, 62, lat);
    check("wrap_lat", 64'(lat), 64'd3);
    check("wrap_out", bus.outport, 64'hC000_0000_0000_0001);
    do_ack("wrap_ack");

    // Full width at offset 5, and saturation of 65
    run(64, 5, lat);
    check("full_lat", 64'(lat), 64'd64);
    check("full_out", bus.outport, 64'hFFFF_FFFF_FFFF_FFFF);
    do_ack("full_ack");
    run(65, 0, lat);
    check("sat_lat", 64'(lat), 64'd64);
    check("sat_out", bus.outport, 64'hFFFF_FFFF_FFFF_FFFF);
    do_ack("sat_ack");

    // Inputs changed during FILL/HOLD, stray acks during FILL
    bus.count_i  = 7'd8;
    bus.offset_i = 6'd0;
    bus.start_i  = 1'b1;
    tick();
    bus.count_i  = 7'd2;
    bus.offset_i = 6'd40;
    check("ign_fill_ready", 64'(bus.ready_o), 64'd0);
    check("ign_out_kept", bus.outport, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      bus.ack_i = (k < 4);
      tick();
    end
    bus.ack_i = 1'b0;
    check("ign_valid", 64'(bus.valid_o), 64'd1);
    check("ign_out", bus.outport, 64'h0000_0000_0000_00FF);
    tick();
    tick();
    check("ign_hold_valid", 64'(bus.valid_o), 64'd1);
    check("ign_hold_out", bus.outport, 64'h0000_0000_0000_00FF);
    bus.start_i = 1'b0;
    do_ack("ign_ack");

    // Reset in the middle of FILL discards everything
    bus.count_i  = 7'd10;
    bus.offset_i = 6'd3;
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b0;
    #1;
    check("mrst_ready", 64'(bus.ready_o), 64'd1);
    check("mrst_valid", 64'(bus.valid_o), 64'd0);
    check("mrst_out", bus.outport, 64'd0);
    #2;
    rst = 1'b1;
    tick();
    run(1, 63, lat);
    check("post_lat", 64'(lat), 64'd1);
    check("post_out", bus.outport, 64'h8000_0000_0000_0000);
    do_ack("post_ack");

    // Loop-back sweep: counts 0..64 repeated, random offsets
    for (int r = 0; r < 1000; r++) begin
      int c;
      int o;
      int n;
      c = r % 65;
      o = int'($urandom_range(0, 63));
      n = (c > 64) ? 64 : c;
      run(c, o, lat);
      check("lb_lat", 64'(lat), 64'(n));
      check("lb_pop", 64'($countones(bus.outport)), 64'(n));
      check("lb_word", bus.outport, model_word(c, o));
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
